// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit RISC CPU control path.
// Holds the opcode map, the IR fetch-select codes (also used by the IR),
// the controller state enum and the packed strobe bundle the controller
// registers.
package cpu_pkg;

  // Opcode map
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDO = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STO = 4'b0011;
  localparam logic [3:0] OP_PRE = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // IR load select codes
  localparam logic [1:0] FETCH_HOLD = 2'b00;
  localparam logic [1:0] FETCH_B1   = 2'b01;
  localparam logic [1:0] FETCH_B2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_DECODE = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Registered strobe bundle. JZ is carried as an "armed" bit so that the
  // zero flag can still gate pc_load combinationally during EXEC.
  typedef struct packed {
    logic [1:0] fetch;
    logic       pc_inc;
    logic       jmp_ld;
    logic       jz_arm;
    logic       addr_sel;
    logic       rom_rd;
    logic       ram_rd;
    logic       ram_wr;
    logic       reg_rd;
    logic       reg_wr;
    logic       acc_ld;
    logic       alu_add;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = 14'd0;

  // Strobes for an instruction-byte fetch: ROM at PC onto the bus, IR byte
  // selected by sel, PC advanced.
  function automatic ctrl_t fetch_ctrl(input logic [1:0] sel);
    ctrl_t c;
    c          = CTRL_OFF;
    c.fetch    = sel;
    c.rom_rd   = 1'b1;
    c.pc_inc   = 1'b1;
    c.addr_sel = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/op_decode.sv
// op_decode: combinational opcode classifier.
// Ports:
//   ins        in  OPW  opcode from the IR
//   two_byte   out 1    instruction carries a second byte (ad2)
//   mem_rd_rom out 1    LDO: ROM[ad2] -> reg
//   mem_rd_ram out 1    LDA: RAM[ad2] -> reg
//   mem_wr     out 1    STO: reg -> RAM[ad2]
//   acc_op     out 1    PRE/ADD: reg -> accumulator
//   alu_add    out 1    ADD: ALU adds instead of passing through
//   branch     out 1    JMP/JZ
//   cond       out 1    JZ: branch gated by zero flag
//   halt       out 1    HLT
module op_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] ins,
  output logic           two_byte,
  output logic           mem_rd_rom,
  output logic           mem_rd_ram,
  output logic           mem_wr,
  output logic           acc_op,
  output logic           alu_add,
  output logic           branch,
  output logic           cond,
  output logic           halt
);

  // Opcode to class bits; unlisted opcodes fall through as NOP.
  always_comb begin
    two_byte   = 1'b0;
    mem_rd_rom = 1'b0;
    mem_rd_ram = 1'b0;
    mem_wr     = 1'b0;
    acc_op     = 1'b0;
    alu_add    = 1'b0;
    branch     = 1'b0;
    cond       = 1'b0;
    halt       = 1'b0;
    case (ins)
      OPW'(OP_LDO): begin two_byte = 1'b1; mem_rd_rom = 1'b1; end
      OPW'(OP_LDA): begin two_byte = 1'b1; mem_rd_ram = 1'b1; end
      OPW'(OP_STO): begin two_byte = 1'b1; mem_wr     = 1'b1; end
      OPW'(OP_PRE): begin acc_op = 1'b1; end
      OPW'(OP_ADD): begin acc_op = 1'b1; alu_add = 1'b1; end
      OPW'(OP_JMP): begin two_byte = 1'b1; branch = 1'b1; end
      OPW'(OP_JZ):  begin two_byte = 1'b1; branch = 1'b1; cond = 1'b1; end
      OPW'(OP_HLT): begin halt = 1'b1; end
      default:      begin end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: main control FSM of the 8-bit RISC CPU.
// Sequences fetch (1 or 2 bytes), execute and write-back, and drives every
// datapath strobe. Strobes are registered from the next state, so they line
// up with the state they belong to and clear asynchronously on reset.
// Ports:
//   clk, rst (async, active-low), run (start, IDLE only), ins (opcode),
//   zero (ALU zero flag, used by JZ in EXEC)
//   fetch[1:0], pc_inc, pc_load, addr_sel, rom_rd, ram_rd, ram_wr,
//   reg_rd, reg_wr, acc_ld, alu_add, halted
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] ins,
  input  logic           zero,
  output logic [1:0]     fetch,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           addr_sel,
  output logic           rom_rd,
  output logic           ram_rd,
  output logic           ram_wr,
  output logic           reg_rd,
  output logic           reg_wr,
  output logic           acc_ld,
  output logic           alu_add,
  output logic           halted
);

  logic   two_byte_s, rom_s, ram_s, wr_s, acc_s, add_s, br_s, cond_s, halt_s;
  logic   has_wb_s;
  logic   in_wb_s;
  state_t state_r, nxt_state_s;
  ctrl_t  ctrl_r, nxt_ctrl_s;

  op_decode #(.OPW(OPW)) u_dec (
    .ins        (ins),
    .two_byte   (two_byte_s),
    .mem_rd_rom (rom_s),
    .mem_rd_ram (ram_s),
    .mem_wr     (wr_s),
    .acc_op     (acc_s),
    .alu_add    (add_s),
    .branch     (br_s),
    .cond       (cond_s),
    .halt       (halt_s)
  );

  assign has_wb_s = rom_s | ram_s | wr_s | acc_s;

  // Next-state logic.
  always_comb begin
    nxt_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   nxt_state_s = run ? ST_FETCH1 : ST_IDLE;
      ST_FETCH1: nxt_state_s = ST_DECODE;
      ST_DECODE: nxt_state_s = two_byte_s ? ST_FETCH2 : ST_EXEC;
      ST_FETCH2: nxt_state_s = ST_EXEC;
      ST_EXEC:   nxt_state_s = has_wb_s ? ST_WB : (halt_s ? ST_HALT : ST_FETCH1);
      ST_WB:     nxt_state_s = ST_FETCH1;
      ST_HALT:   nxt_state_s = ST_HALT;
      default:   nxt_state_s = ST_IDLE;
    endcase
  end

  // Strobe decode for the state about to be entered. The opcode is already
  // valid whenever EXEC/WB is next, since byte 1 is loaded leaving FETCH1.
  // Write strobes are held to WB so the bus has settled for one cycle.
  always_comb begin
    nxt_ctrl_s = CTRL_OFF;
    in_wb_s    = (nxt_state_s == ST_WB);
    case (nxt_state_s)
      ST_FETCH1: nxt_ctrl_s = fetch_ctrl(FETCH_B1);
      ST_FETCH2: nxt_ctrl_s = fetch_ctrl(FETCH_B2);
      ST_EXEC, ST_WB: begin
        nxt_ctrl_s.addr_sel = rom_s | ram_s | wr_s;
        nxt_ctrl_s.rom_rd   = rom_s;
        nxt_ctrl_s.ram_rd   = ram_s;
        nxt_ctrl_s.reg_rd   = wr_s | acc_s;
        nxt_ctrl_s.alu_add  = add_s;
        nxt_ctrl_s.reg_wr   = in_wb_s & (rom_s | ram_s);
        nxt_ctrl_s.ram_wr   = in_wb_s & wr_s;
        nxt_ctrl_s.acc_ld   = in_wb_s & acc_s;
        nxt_ctrl_s.jmp_ld   = ~in_wb_s & br_s & ~cond_s;
        nxt_ctrl_s.jz_arm   = ~in_wb_s & br_s & cond_s;
      end
      ST_HALT:   nxt_ctrl_s.halted = 1'b1;
      default:   nxt_ctrl_s = CTRL_OFF;
    endcase
  end

  // State and registered strobes; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ctrl_r  <= CTRL_OFF;
    end else begin
      state_r <= nxt_state_s;
      ctrl_r  <= nxt_ctrl_s;
    end
  end

  assign fetch    = ctrl_r.fetch;
  assign pc_inc   = ctrl_r.pc_inc;
  // JZ looks at the live zero flag while in EXEC.
  assign pc_load  = ctrl_r.jmp_ld | (ctrl_r.jz_arm & zero);
  assign addr_sel = ctrl_r.addr_sel;
  assign rom_rd   = ctrl_r.rom_rd;
  assign ram_rd   = ctrl_r.ram_rd;
  assign ram_wr   = ctrl_r.ram_wr;
  assign reg_rd   = ctrl_r.reg_rd;
  assign reg_wr   = ctrl_r.reg_wr;
  assign acc_ld   = ctrl_r.acc_ld;
  assign alu_add  = ctrl_r.alu_add;
  assign halted   = ctrl_r.halted;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: scoreboard bench for cpu_ctrl. The stimulus process walks a
// program of random opcodes cycle by cycle, pushing the strobe pattern each
// cycle should show (from a per-opcode table); a negedge monitor pops and
// compares against the DUT.
module tb_cpu_ctrl;

  localparam logic [3:0] NOP = 4'h0, LDO = 4'h1, LDA = 4'h2, STO = 4'h3;
  localparam logic [3:0] PRE = 4'h4, ADD = 4'h5, JMP = 4'h6, JZ = 4'h7;
  localparam logic [3:0] HLT = 4'hF;

  localparam int PH_IDLE = 0, PH_F1 = 1, PH_DEC = 2, PH_F2 = 3;
  localparam int PH_EXEC = 4, PH_WB = 5, PH_HALT = 6;

  // vector bit positions: {fetch[1:0], pc_inc, pc_load, addr_sel, rom_rd,
  // ram_rd, ram_wr, reg_rd, reg_wr, acc_ld, alu_add, halted}
  localparam int B_HALT = 0, B_ALU = 1, B_ACC = 2, B_REGWR = 3, B_REGRD = 4;
  localparam int B_RAMWR = 5, B_RAMRD = 6, B_ROMRD = 7, B_ADDR = 8;
  localparam int B_PCLD = 9, B_PCINC = 10;

  typedef logic [12:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] ins = 4'h0;
  logic       zero = 1'b0;
  logic [1:0] fetch;
  logic       pc_inc, pc_load, addr_sel, rom_rd, ram_rd, ram_wr;
  logic       reg_rd, reg_wr, acc_ld, alu_add, halted;
  vec_t       act_s;

  vec_t  exp_q[$];
  string name_q[$];
  int    vec_cnt = 0;
  int    err_cnt = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.OPW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .ins(ins), .zero(zero),
    .fetch(fetch), .pc_inc(pc_inc), .pc_load(pc_load), .addr_sel(addr_sel),
    .rom_rd(rom_rd), .ram_rd(ram_rd), .ram_wr(ram_wr), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .acc_ld(acc_ld), .alu_add(alu_add), .halted(halted)
  );

  assign act_s = {fetch, pc_inc, pc_load, addr_sel, rom_rd, ram_rd, ram_wr,
                  reg_rd, reg_wr, acc_ld, alu_add, halted};

  function automatic bit two_byte(input logic [3:0] op);
    return (op == LDO) || (op == LDA) || (op == STO) || (op == JMP) || (op == JZ);
  endfunction

  function automatic bit has_wb(input logic [3:0] op);
    return (op == LDO) || (op == LDA) || (op == STO) || (op == PRE) || (op == ADD);
  endfunction

  // Strobes expected in a given phase of an instruction.
  function automatic vec_t exp_vec(input int ph, input logic [3:0] op, input logic z);
    vec_t v;
    bit   wb;
    v  = 13'd0;
    wb = (ph == PH_WB);
    case (ph)
      PH_F1:   begin v[12:11] = 2'b01; v[B_PCINC] = 1'b1; v[B_ROMRD] = 1'b1; end
      PH_F2:   begin v[12:11] = 2'b10; v[B_PCINC] = 1'b1; v[B_ROMRD] = 1'b1; end
      PH_HALT: v[B_HALT] = 1'b1;
      PH_EXEC, PH_WB: begin
        case (op)
          LDO: begin v[B_ADDR] = 1'b1; v[B_ROMRD] = 1'b1; v[B_REGWR] = wb; end
          LDA: begin v[B_ADDR] = 1'b1; v[B_RAMRD] = 1'b1; v[B_REGWR] = wb; end
          STO: begin v[B_ADDR] = 1'b1; v[B_REGRD] = 1'b1; v[B_RAMWR] = wb; end
          PRE: begin v[B_REGRD] = 1'b1; v[B_ACC] = wb; end
          ADD: begin v[B_REGRD] = 1'b1; v[B_ALU] = 1'b1; v[B_ACC] = wb; end
          JMP: v[B_PCLD] = !wb;
          JZ:  v[B_PCLD] = !wb && z;
          default: begin end
        endcase
      end
      default: begin end
    endcase
    return v;
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %013b want %013b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the scoreboard once per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), act_s, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input vec_t v);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  // Entered one time unit after the edge into FETCH1; returns likewise at
  // the next FETCH1 (or inside HALT for HLT).
  task automatic do_instr(input logic [3:0] op, input bit force_z, input logic zval);
    logic z;
    push("fetch1", exp_vec(PH_F1, op, 1'b0));
    zero = 1'($urandom); run = 1'($urandom);
    tick();
    ins = op;
    push("decode", exp_vec(PH_DEC, op, 1'b0));
    zero = 1'($urandom); run = 1'($urandom);
    if (two_byte(op)) begin
      tick();
      push("fetch2", exp_vec(PH_F2, op, 1'b0));
      zero = 1'($urandom);
    end
    tick();
    z = force_z ? zval : 1'($urandom);
    zero = z;
    push("exec", exp_vec(PH_EXEC, op, z));
    if (has_wb(op)) begin
      tick();
      zero = 1'($urandom);
      push("wb", exp_vec(PH_WB, op, 1'b0));
    end
    tick();
    if (op == HLT) begin
      for (int i = 0; i < 20; i++) begin
        push("halt", exp_vec(PH_HALT, op, 1'b0));
        run = 1'($urandom); zero = 1'($urandom);
        tick();
      end
    end
  endtask

  // Release reset with run low, confirm IDLE waits, then start the CPU.
  task automatic release_and_start();
    rst = 1'b1; run = 1'b0;
    push("idle", 13'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      zero = 1'($urandom);
      push("idle", 13'd0);
    end
    run = 1'b1;
    tick();
  endtask

  // LDA up to WB, then reset mid-WB: strobes must drop before the next edge.
  task automatic lda_reset();
    push("fetch1", exp_vec(PH_F1, LDA, 1'b0));
    tick(); ins = LDA; push("decode", 13'd0);
    tick(); push("fetch2", exp_vec(PH_F2, LDA, 1'b0));
    tick(); push("exec", exp_vec(PH_EXEC, LDA, 1'b0));
    tick();
    check("lda_wb_before_reset", act_s, exp_vec(PH_WB, LDA, 1'b0));
    rst = 1'b0;
    #1;
    check("reset_mid_wb", act_s, 13'd0);
    tick();
    tick();
    check("reset_held", act_s, 13'd0);
  endtask

  logic [3:0] op;

  initial begin
    #1 rst = 1'b0;
    #2 check("reset_async", act_s, 13'd0);
    run = 1'b1;
    tick();
    check("reset_run_ignored", act_s, 13'd0);
    release_and_start();

    do_instr(NOP, 1'b0, 1'b0);
    do_instr(LDO, 1'b0, 1'b0);
    do_instr(JZ,  1'b1, 1'b0);
    do_instr(JZ,  1'b1, 1'b1);
    do_instr(STO, 1'b0, 1'b0);
    do_instr(PRE, 1'b0, 1'b0);
    do_instr(ADD, 1'b0, 1'b0);
    do_instr(JMP, 1'b0, 1'b0);
    do_instr(4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      do_instr(op, 1'b0, 1'b0);
    end

    lda_reset();
    release_and_start();
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 14));
      do_instr(op, 1'b0, 1'b0);
    end
    do_instr(HLT, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
